// File: rtl/run_ctrl_pkg.sv
// Shared types for the core run sequencer: FSM states and run completion status codes.
package run_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, LAUNCH = 2'b01, RUN = 2'b10, DONE = 2'b11} run_state_t;
    typedef enum logic [1:0] {ST_OK = 2'b00, ST_TIMEOUT = 2'b01, ST_ABORT = 2'b10} run_status_t;
endpackage

// File: rtl/run_cycle_counter.sv
// Saturating RUN-cycle counter with a terminal-count flag one step before the watchdog limit.
module run_cycle_counter #(
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 60000
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(MAX_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != CNT_SAT))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC_VAL);
endmodule

// File: rtl/core_run_ctrl.sv
// Run sequencer for the 9-bit core: parks/launches the core via CoreStart, counts RUN cycles
// until CoreAck, and reports status with watchdog timeout and host abort.
module core_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int PROG_W       = 2,
    parameter int CNT_W        = 16,
    parameter int START_CYCLES = 2,
    parameter int MAX_CYCLES   = 60000
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              RunReq,
    input  logic [PROG_W-1:0] ProgSel,
    input  logic              Abort,
    output logic              RunRdy,
    output logic              CoreStart,
    output logic [PROG_W-1:0] CoreProg,
    input  logic              CoreAck,
    output logic              RunDone,
    output logic [1:0]        Status,
    output logic [CNT_W-1:0]  CycleCount
);
    localparam int LW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [LW-1:0] LAUNCH_LOAD = LW'(START_CYCLES - 1);

    run_state_t        state_q, state_d;
    run_status_t       status_q, status_d;
    logic [LW-1:0]     launch_q, launch_d;
    logic [PROG_W-1:0] prog_q, prog_d;
    logic              rdy_q, start_q, done_q;
    logic              cnt_clr, cnt_en, cnt_tc;

    run_cycle_counter #(.CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)) u_cnt (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .cnt_o   (CycleCount),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        launch_d = launch_q;
        prog_d   = prog_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (RunReq) begin
                    state_d  = LAUNCH;
                    prog_d   = ProgSel;
                    status_d = ST_OK;
                    launch_d = LAUNCH_LOAD;
                    cnt_clr  = 1'b1;
                end
            end
            LAUNCH: begin
                // CoreAck is ignored here: the core still reflects the previous program's PC.
                if (Abort) begin
                    state_d  = DONE;
                    status_d = ST_ABORT;
                end else if (launch_q == '0) begin
                    state_d = RUN;
                end else begin
                    launch_d = launch_q - LW'(1);
                end
            end
            RUN: begin
                if (CoreAck) begin
                    state_d  = DONE;
                    status_d = ST_OK;
                end else if (Abort) begin
                    state_d  = DONE;
                    status_d = ST_ABORT;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        state_d  = DONE;
                        status_d = ST_TIMEOUT;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output flags are registered from the next state so they line up with state_q.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            status_q <= ST_OK;
            launch_q <= '0;
            prog_q   <= '0;
            rdy_q    <= 1'b1;
            start_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            launch_q <= launch_d;
            prog_q   <= prog_d;
            rdy_q    <= (state_d == IDLE);
            start_q  <= (state_d != RUN);
            done_q   <= (state_d == DONE);
        end
    end

    assign RunRdy    = rdy_q;
    assign CoreStart = start_q;
    assign RunDone   = done_q;
    assign CoreProg  = prog_q;
    assign Status    = status_q;
endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: expected run results are queued at launch and checked on RunDone.
module tb_core_run_ctrl;
    localparam int PROG_W = 2;
    localparam int CNT_W  = 16;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              RunReq = 1'b0;
    logic [PROG_W-1:0] ProgSel = '0;
    logic              Abort = 1'b0;
    logic              CoreAck = 1'b0;
    logic              RunRdy, CoreStart, RunDone;
    logic [PROG_W-1:0] CoreProg;
    logic [1:0]        Status;
    logic [CNT_W-1:0]  CycleCount;

    typedef struct {
        logic [1:0]        st;
        logic [CNT_W-1:0]  cnt;
        logic [PROG_W-1:0] prog;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    core_run_ctrl #(.PROG_W(PROG_W), .CNT_W(CNT_W), .START_CYCLES(2), .MAX_CYCLES(20)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .RunReq     (RunReq),
        .ProgSel    (ProgSel),
        .Abort      (Abort),
        .RunRdy     (RunRdy),
        .CoreStart  (CoreStart),
        .CoreProg   (CoreProg),
        .CoreAck    (CoreAck),
        .RunDone    (RunDone),
        .Status     (Status),
        .CycleCount (CycleCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        else             n_pass++;
    endtask

    // Scoreboard: every RunDone pulse must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (Reset_n && RunDone) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_status", 32'(Status), 32'(e.st));
                chk("sb_count", 32'(CycleCount), 32'(e.cnt));
                chk("sb_prog", 32'(CoreProg), 32'(e.prog));
                chk("sb_done_park", 32'(CoreStart), 1);
            end
        end
    end

    task automatic start_run(input logic [PROG_W-1:0] p, input logic [1:0] st, input int cnt);
        exp_t e;
        e.st = st; e.cnt = CNT_W'(cnt); e.prog = p;
        sb_q.push_back(e);
        @(posedge Clk); #1;
        ProgSel = p; RunReq = 1'b1;
        @(posedge Clk); #1;
        RunReq = 1'b0;
    endtask

    // Returns at the negedge where CoreStart is first seen low; hi = launch cycles observed.
    task automatic wait_fall(output int hi);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (!CoreStart) return;
            hi++;
        end
        chk("fall_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (RunDone) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 want 1");
        $fatal(1, "bench timeout");
    end

    initial begin
        int hi;
        // 1: reset
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_rdy", 32'(RunRdy), 1);
        chk("rst_start", 32'(CoreStart), 1);
        chk("rst_status", 32'(Status), 0);
        chk("rst_count", 32'(CycleCount), 0);
        chk("rst_done", 32'(RunDone), 0);
        @(posedge Clk); #1; Reset_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_rdy", 32'(RunRdy), 1);
        chk("post_rst_prog", 32'(CoreProg), 0);

        // 2: normal run, Ack 10 cycles after CoreStart falls
        start_run(2'd2, 2'b00, 10);
        chk("launch_rdy", 32'(RunRdy), 0);
        wait_fall(hi);
        chk("launch_len", 32'(hi), 2);
        chk("run_prog", 32'(CoreProg), 2);
        repeat (10) @(posedge Clk);
        #1; CoreAck = 1'b1;
        wait_done(10);
        @(posedge Clk); #1; CoreAck = 1'b0;
        @(negedge Clk);
        chk("after_rdy", 32'(RunRdy), 1);
        chk("after_done", 32'(RunDone), 0);
        chk("after_status", 32'(Status), 0);

        // 3: watchdog timeout; Ack during IDLE/LAUNCH must be ignored
        CoreAck = 1'b1;
        start_run(2'd1, 2'b01, 20);
        wait_fall(hi);
        CoreAck = 1'b0;
        wait_done(40);
        chk("to_status_hold", 32'(Status), 1);

        // 4a: abort in second LAUNCH cycle
        start_run(2'd3, 2'b10, 0);
        @(posedge Clk); #1; Abort = 1'b1;
        @(posedge Clk); #1; Abort = 1'b0;
        wait_done(5);

        // 4b: Abort and Ack together in RUN -> Ack wins
        start_run(2'd0, 2'b00, 3);
        wait_fall(hi);
        repeat (3) @(posedge Clk);
        #1; Abort = 1'b1; CoreAck = 1'b1;
        wait_done(5);
        @(posedge Clk); #1; Abort = 1'b0; CoreAck = 1'b0;

        // 4c: Abort alone in RUN keeps the cycles counted so far
        start_run(2'd1, 2'b10, 5);
        wait_fall(hi);
        repeat (5) @(posedge Clk);
        #1; Abort = 1'b1;
        wait_done(5);
        @(posedge Clk); #1;
        // Abort stays high into IDLE: must not start or end anything
        repeat (3) @(negedge Clk);
        chk("idle_abort_rdy", 32'(RunRdy), 1);
        @(posedge Clk); #1; Abort = 1'b0;

        // 5: async reset mid-run, no RunDone
        begin
            exp_t e;
            start_run(2'd2, 2'b00, 0);
            e = sb_q.pop_back();
        end
        wait_fall(hi);
        repeat (5) @(posedge Clk);
        #2; Reset_n = 1'b0;
        #1;
        chk("arst_rdy", 32'(RunRdy), 1);
        chk("arst_start", 32'(CoreStart), 1);
        chk("arst_prog", 32'(CoreProg), 0);
        chk("arst_count", 32'(CycleCount), 0);
        chk("arst_status", 32'(Status), 0);
        chk("arst_done", 32'(RunDone), 0);
        repeat (2) @(posedge Clk);
        #1; Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        chk("arst_idle", 32'(RunRdy), 1);

        // 6: RunReq held -> back-to-back runs, Ack held so each run ends in its first RUN cycle
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.st = 2'b00; e.cnt = '0; e.prog = 2'd1;
            sb_q.push_back(e);
        end
        @(posedge Clk); #1;
        ProgSel = 2'd1; RunReq = 1'b1; CoreAck = 1'b1;
        for (int r = 0; r < 2; r++) begin
            wait_done(10);
            @(negedge Clk);
            chk("b2b_idle", 32'(RunRdy), 1);
            @(negedge Clk);
            chk("b2b_relaunch", 32'(RunRdy), 0);
        end
        wait_done(10);
        @(posedge Clk); #1; RunReq = 1'b0; CoreAck = 1'b0;
        repeat (6) @(negedge Clk);
        chk("b2b_stop_rdy", 32'(RunRdy), 1);
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
